// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial accumulator.
// Holds the FSM encoding, the adder slice width and a counter-width helper.
package nsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 4;

    // Minimum bit width able to index n items, never less than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/adder4_slice.sv
// Behavioural model of the 4-bit adder cell shared by add/sub techmaps.
// Purely combinational: {CO, S} = A + B + CI.
module adder4_slice (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       CI,
    output logic [3:0] S,
    output logic       CO
);

    logic [4:0] w_sum;

    assign w_sum = {1'b0, A} + {1'b0, B} + {4'b0000, CI};
    assign S     = w_sum[3:0];
    assign CO    = w_sum[4];

endmodule

// File: rtl/nibble_serial_accumulator.sv
// Accumulator that adds/subtracts a WIDTH-bit operand one nibble per clock
// through a single 4-bit adder slice, with valid/ready on both sides.
module nibble_serial_accumulator
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sub,
    input  logic             in_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam int NIB   = WIDTH / SLICE_W;
    localparam int CNT_W = clog2(NIB);

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
            $error("nibble_serial_accumulator: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_sub;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_last;
    logic [3:0]         w_a;
    logic [3:0]         w_b;
    logic [3:0]         w_s;
    logic               w_co;

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == CNT_W'(NIB - 1));

    // Select the nibble addressed by the counter; B is inverted for subtract.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int k = 0; k < NIB; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_a = r_acc[k*SLICE_W +: SLICE_W];
                w_b = r_opnd[k*SLICE_W +: SLICE_W] ^ {SLICE_W{r_sub}};
            end
        end
    end

    adder4_slice u_slice (
        .A  (w_a),
        .B  (w_b),
        .CI (r_carry),
        .S  (w_s),
        .CO (w_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = in_clr ? DONE : RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_opnd  <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (in_clr) begin
                            r_acc  <= in_data;
                            r_cout <= 1'b0;
                            r_ovf  <= 1'b0;
                        end else begin
                            r_opnd  <= in_data;
                            r_sub   <= in_sub;
                            r_carry <= in_sub;
                            r_cnt   <= '0;
                        end
                    end
                end
                RUN: begin
                    for (int k = 0; k < NIB; k++) begin
                        if (r_cnt == CNT_W'(k)) begin
                            r_acc[k*SLICE_W +: SLICE_W] <= w_s;
                        end
                    end
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_cout <= w_co;
                        r_ovf  <= (w_a[3] == w_b[3]) && (w_s[3] != w_a[3]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_acc   = r_acc;
    assign out_carry = r_cout;
    assign out_ovf   = r_ovf;

endmodule
